// File: rtl/rr_burst_arbiter.sv
// Packet-granularity round-robin arbiter: a granted requester keeps the sink
// until its last beat is accepted, then priority rotates past it.
module rr_burst_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    input  logic           out_ready,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           xfer
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] next_owner;
    logic [IDW-1:0] base;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic [IDW:0]   scan;
    logic [N-1:0]   win_onehot;
    logic           found;
    logic           eob;

    assign grant_valid = |grant;
    assign xfer        = |(grant & req) & out_ready;
    assign eob         = xfer & |(grant & last);
    assign next_owner  = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
    assign win_onehot  = N'(1) << win;

    // Wrap-around scan starting at ptr when idle, or just past the owner when a
    // burst is ending, so back-to-back bursts are re-arbitrated in the same edge.
    always_comb begin
        base  = (state == LOCKED) ? next_owner : ptr;
        found = 1'b0;
        win   = '0;
        scan  = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, base} + (IDW + 1)'(k);
            if (scan >= (IDW + 1)'(N)) begin
                scan = scan - (IDW + 1)'(N);
            end
            idx = scan[IDW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= win_onehot;
                        grant_id <= win;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Only an accepted last releases the lock; anything else holds.
                    if (eob) begin
                        ptr <= next_owner;
                        if (found) begin
                            grant    <= win_onehot;
                            grant_id <= win;
                        end else begin
                            grant    <= '0;
                            grant_id <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    grant_id <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed and randomized bench for rr_burst_arbiter, checked against an
// integer owner/pointer model of the round-robin burst rules.
module tb_rr_burst_arbiter;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           xfer;

    int checks = 0;
    int passes = 0;

    // Reference model: owner index (-1 when idle) and rotation pointer.
    int owner = -1;
    int mptr  = 0;

    rr_burst_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .last       (last),
        .out_ready  (out_ready),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .xfer       (xfer)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input logic r_rst, input logic [N-1:0] r_req,
                                 input logic [N-1:0] r_last, input logic r_ready);
        logic [N-1:0] eg;
        logic         ex;
        @(negedge clk);
        rst       = r_rst;
        req       = r_req;
        last      = r_last;
        out_ready = r_ready;
        #1;
        eg = '0;
        ex = 1'b0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ex = r_req[owner] & r_ready;
        end
        checkOutput("grant",       32'(grant),       32'(eg));
        checkOutput("grant_valid", 32'(grant_valid), 32'(owner >= 0));
        checkOutput("grant_id",    32'(grant_id),    (owner >= 0) ? 32'(owner) : 32'd0);
        checkOutput("xfer",        32'(xfer),        32'(ex));
        @(posedge clk);
        if (r_rst) begin
            owner = -1;
            mptr  = 0;
        end else if (owner < 0) begin
            owner = pick(r_req, mptr);
        end else if (r_req[owner] && r_ready && r_last[owner]) begin
            mptr  = (owner + 1) % N;
            owner = pick(r_req, mptr);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        last      = '0;
        out_ready = 1'b0;
        @(posedge clk);

        // Reset then idle
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1);

        // Single-beat rotation with all requesters active
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);

        // Burst lock with backpressure; requester 2 joins mid-burst
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0101, 4'b0100, 1'b0);
        applyStimulus(1'b0, 4'b0101, 4'b0100, 1'b1);
        applyStimulus(1'b0, 4'b0101, 4'b0001, 1'b1);
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);

        // Skip and wrap: idle requester 3 is passed over
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b1);
        applyStimulus(1'b0, 4'b0101, 4'b0101, 1'b1);
        applyStimulus(1'b0, 4'b0101, 4'b0101, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);

        // Owner gap: requester 1 drops req while requester 3 waits
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b1010, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b1000, 4'b1010, 1'b1);
        applyStimulus(1'b0, 4'b1000, 4'b1010, 1'b1);
        applyStimulus(1'b0, 4'b1010, 4'b0010, 1'b1);
        applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0);

        // Reset mid-burst abandons the burst and restores requester 0 priority
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          N'($urandom & $urandom),
                          N'($urandom),
                          ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
